// File: rtl/mem_pkg.sv
// Shared constants for the load/store front end:
// RV32I funct3 codes, FSM state encoding, RAM geometry.
package mem_pkg;

  localparam int RAM_AW = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a RAM word and
// sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{addr, 3'b000} +: 8];
    lane_h = word[{addr[1], 4'b0000} +: 16];
    data   = word;
    unique case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store front end to a 1024x32 word RAM;
// sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RESP_VALID,
  output logic [31:0]       RESP_RDATA,
  output logic              RESP_FAULT,
  output logic [RAM_AW-1:0] RAM_ADDRESS,
  output logic [31:0]       RAM_DATA_IN,
  output logic              RAM_WRITE_ENABLE,
  input  logic [31:0]       RAM_DATA_OUT
);

  state_t      state;
  logic        write_q;
  logic        fault_q;
  logic [2:0]  f3_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] merged;
  logic [31:0] aligned;
  logic        fault;
  logic        sub_word;
  logic        unused_hi;

  // upper address bits alias onto the 4 KiB RAM
  assign unused_hi = ^REQ_ADDR[31:12];

  always_comb begin
    fault = 1'b0;
    unique case (REQ_FUNCT3)
      F3_B:    fault = 1'b0;
      F3_H:    fault = REQ_ADDR[0];
      F3_W:    fault = |REQ_ADDR[1:0];
      F3_BU:   fault = REQ_WRITE;
      F3_HU:   fault = REQ_WRITE | REQ_ADDR[0];
      default: fault = 1'b1;
    endcase
  end

  assign sub_word = (REQ_FUNCT3 == F3_B)
                  | (REQ_FUNCT3 == F3_H);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 12'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: if (REQ_VALID) begin
          write_q <= REQ_WRITE;
          fault_q <= fault;
          f3_q    <= REQ_FUNCT3;
          addr_q  <= REQ_ADDR[11:0];
          wdata_q <= REQ_WDATA;
          if (fault)
            state <= S_RESP;
          else if (!REQ_WRITE || sub_word)
            state <= S_READ;
          else
            state <= S_WRITE;
        end
        S_READ: begin
          word_q <= RAM_DATA_OUT;
          state  <= write_q ? S_WRITE : S_RESP;
        end
        S_WRITE: state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    merged = wdata_q;
    if (f3_q == F3_B) begin
      merged = word_q;
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (f3_q == F3_H) begin
      merged = word_q;
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  load_align u_align (
    .word   (word_q),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (aligned)
  );

  assign REQ_READY  = (state == S_IDLE);
  assign RESP_VALID = (state == S_RESP);
  assign RESP_FAULT = RESP_VALID & fault_q;
  assign RESP_RDATA = (RESP_VALID & ~write_q & ~fault_q)
                    ? aligned : 32'd0;

  assign RAM_ADDRESS      = addr_q[11:2];
  assign RAM_DATA_IN      = (state == S_WRITE) ? merged : 32'd0;
  assign RAM_WRITE_ENABLE = (state == S_WRITE) & ~RESET;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level
// reference model, per-cycle output compare and directed checks.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WRITE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = 3'd0;
  logic [31:0] REQ_ADDR = 32'd0;
  logic [31:0] REQ_WDATA = 32'd0;
  logic        REQ_READY;
  logic        RESP_VALID;
  logic        RESP_FAULT;
  logic [31:0] RESP_RDATA;
  logic [9:0]  RAM_ADDRESS;
  logic [31:0] RAM_DATA_IN;
  logic        RAM_WRITE_ENABLE;
  logic [31:0] RAM_DATA_OUT;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];

  always #5 CLK = ~CLK;

  assign RAM_DATA_OUT = ram[RAM_ADDRESS];

  mem_access_unit dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .REQ_VALID        (REQ_VALID),
    .REQ_READY        (REQ_READY),
    .REQ_WRITE        (REQ_WRITE),
    .REQ_FUNCT3       (REQ_FUNCT3),
    .REQ_ADDR         (REQ_ADDR),
    .REQ_WDATA        (REQ_WDATA),
    .RESP_VALID       (RESP_VALID),
    .RESP_RDATA       (RESP_RDATA),
    .RESP_FAULT       (RESP_FAULT),
    .RAM_ADDRESS      (RAM_ADDRESS),
    .RAM_DATA_IN      (RAM_DATA_IN),
    .RAM_WRITE_ENABLE (RAM_WRITE_ENABLE),
    .RAM_DATA_OUT     (RAM_DATA_OUT)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 0) return 32'h01234567;
    return (32'(i) * 32'h9E3779B9) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w,
                                            input logic [31:0] wd,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [31:0] m;
    if (f3 == 3'd0) begin
      m = 32'hFF << (8 * off);
      return (w & ~m) | ((wd & 32'hFF) << (8 * off));
    end
    if (f3 == 3'd1) begin
      m = 32'hFFFF << (16 * off[1]);
      return (w & ~m) | ((wd & 32'hFFFF) << (16 * off[1]));
    end
    return wd;
  endfunction

  function automatic bit is_fault(input bit w,
                                  input logic [2:0] f3,
                                  input logic [1:0] off);
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return off[0];
      3'd2:    return off != 2'd0;
      3'd4:    return w;
      3'd5:    return w || off[0];
      default: return 1'b1;
    endcase
  endfunction

  // bench-side RAM: combinational read, write on rising edge
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = init_val(i);
    forever begin
      @(posedge CLK);
      if (RAM_WRITE_ENABLE) ram[RAM_ADDRESS] = RAM_DATA_IN;
    end
  end

  // reference model: one transaction, timed in cycles after handshake
  int          edges = 0;
  int          hs = 0;
  int          hs_cnt = 0;
  int          resp_n = 0;
  int          we_n = 0;
  bit          pend = 1'b0;
  bit          has_wr = 1'b0;
  bit          m_fault = 1'b0;
  bit          started = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] m_wdat = 32'd0;
  logic [9:0]  m_idx = 10'd0;
  logic [9:0]  last_idx = 10'd0;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge CLK);
      if (RESET) begin
        pend = 1'b0;
        last_idx = 10'd0;
        started = 1'b1;
      end else begin
        if (pend && has_wr && edges == hs + we_n - 1)
          ref_mem[m_idx] = m_wdat;
        if (pend && edges == hs + resp_n - 1)
          pend = 1'b0;
        if (REQ_VALID && REQ_READY) begin
          pend = 1'b1;
          hs = edges + 1;
          hs_cnt++;
          m_idx = REQ_ADDR[11:2];
          last_idx = m_idx;
          m_fault = is_fault(REQ_WRITE, REQ_FUNCT3, REQ_ADDR[1:0]);
          has_wr = REQ_WRITE && !m_fault;
          m_rdata = (REQ_WRITE || m_fault) ? 32'd0 :
                    load_val(ref_mem[m_idx], REQ_FUNCT3, REQ_ADDR[1:0]);
          m_wdat = store_val(ref_mem[m_idx], REQ_WDATA,
                             REQ_FUNCT3, REQ_ADDR[1:0]);
          if (m_fault) begin
            resp_n = 1; we_n = 0;
          end else if (!REQ_WRITE) begin
            resp_n = 2; we_n = 0;
          end else if (REQ_FUNCT3 == 3'd2) begin
            resp_n = 2; we_n = 1;
          end else begin
            resp_n = 3; we_n = 2;
          end
        end
      end
      edges++;
    end
  end

  int          resp_cnt = 0;
  int          we_cnt = 0;
  int          last_lat = 0;
  int          last_we_lat = 0;
  logic [31:0] last_rdata = 32'd0;
  logic [31:0] last_we_data = 32'd0;
  logic [9:0]  last_we_addr = 10'd0;
  logic [9:0]  last_ra = 10'd0;
  bit          last_fault = 1'b0;

  always @(negedge CLK) begin
    bit in_wr;
    bit rv;
    if (started) begin
      in_wr = pend && has_wr && edges == hs + we_n - 1;
      rv = pend && edges == hs + resp_n - 1;
      check("req_ready", 32'(REQ_READY), 32'(!pend));
      check("resp_valid", 32'(RESP_VALID), 32'(rv));
      check("resp_fault", 32'(RESP_FAULT), 32'(rv && m_fault));
      check("resp_rdata", RESP_RDATA, rv ? m_rdata : 32'd0);
      check("ram_we", 32'(RAM_WRITE_ENABLE), 32'(in_wr && !RESET));
      check("ram_data_in", RAM_DATA_IN, in_wr ? m_wdat : 32'd0);
      check("ram_address", 32'(RAM_ADDRESS), 32'(last_idx));
      if (RAM_WRITE_ENABLE) begin
        we_cnt++;
        last_we_lat = edges - hs + 1;
        last_we_addr = RAM_ADDRESS;
        last_we_data = RAM_DATA_IN;
      end
      if (RESP_VALID) begin
        resp_cnt++;
        last_lat = edges - hs + 1;
        last_rdata = RESP_RDATA;
        last_fault = RESP_FAULT;
        last_ra = RAM_ADDRESS;
      end
    end
  end

  int resp_base = 0;
  int we_base = 0;

  task automatic issue(input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int n0;
    n0 = hs_cnt;
    resp_base = resp_cnt;
    we_base = we_cnt;
    REQ_WRITE = w;
    REQ_FUNCT3 = f3;
    REQ_ADDR = a;
    REQ_WDATA = wd;
    REQ_VALID = 1'b1;
    for (int k = 0; k < 20 && hs_cnt == n0; k++) begin
      @(posedge CLK);
      #1;
    end
    check("handshake", 32'(hs_cnt - n0), 32'd1);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_resp();
    for (int k = 0; k < 20 && resp_cnt == resp_base; k++) begin
      @(posedge CLK);
      #1;
    end
    check("resp_seen", 32'(resp_cnt - resp_base), 32'd1);
  endtask

  task automatic op(input bit w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    issue(w, f3, a, wd);
    wait_resp();
  endtask

  task automatic lit_load(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] exp);
    op(1'b0, f3, a, 32'd0);
    check(name, last_rdata, exp);
    check({name, "_lat"}, 32'(last_lat), 32'd2);
  endtask

  task automatic lit_fault(input string name, input bit w,
                           input logic [2:0] f3, input logic [31:0] a);
    op(w, f3, a, 32'hFFFF_FFFF);
    check({name, "_fault"}, 32'(last_fault), 32'd1);
    check({name, "_lat"}, 32'(last_lat), 32'd1);
    check({name, "_rdata"}, last_rdata, 32'd0);
    check({name, "_writes"}, 32'(we_cnt - we_base), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1;
    int n0;
    int bad;
    bit w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] hi;

    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("reset_ready", 32'(REQ_READY), 32'd1);
    check("reset_addr", 32'(RAM_ADDRESS), 32'd0);

    op(1'b0, 3'd2, 32'h10, 32'd0);
    check("lw_rdata", last_rdata, 32'hDEADBEEF);
    check("lw_lat", 32'(last_lat), 32'd2);
    check("lw_fault", 32'(last_fault), 32'd0);
    check("lw_writes", 32'(we_cnt - we_base), 32'd0);

    op(1'b1, 3'd0, 32'h13, 32'h123456AA);
    check("sb_writes", 32'(we_cnt - we_base), 32'd1);
    check("sb_we_lat", 32'(last_we_lat), 32'd2);
    check("sb_we_addr", 32'(last_we_addr), 32'd4);
    check("sb_we_data", last_we_data, 32'hAAADBEEF);
    check("sb_lat", 32'(last_lat), 32'd3);
    check("sb_rdata", last_rdata, 32'd0);

    lit_load("lb", 3'd0, 32'h13, 32'hFFFFFFAA);
    lit_load("lbu", 3'd4, 32'h13, 32'h000000AA);
    lit_load("lh", 3'd1, 32'h12, 32'hFFFFAAAD);
    lit_load("lhu", 3'd5, 32'h12, 32'h0000AAAD);

    op(1'b1, 3'd1, 32'h10, 32'h00007777);
    check("sh_writes", 32'(we_cnt - we_base), 32'd1);
    lit_load("lw_after_sh", 3'd2, 32'h10, 32'hAAAD7777);

    op(1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    check("sw_we_lat", 32'(last_we_lat), 32'd1);
    check("sw_lat", 32'(last_lat), 32'd2);

    lit_fault("sw_mis", 1'b1, 3'd2, 32'h06);
    lit_fault("lh_mis", 1'b0, 3'd1, 32'h11);
    lit_fault("f3_011", 1'b0, 3'd3, 32'h10);
    lit_fault("st_f3_100", 1'b1, 3'd4, 32'h10);

    lit_load("alias_0", 3'd2, 32'h1000, 32'h01234567);
    op(1'b0, 3'd2, 32'hFFC, 32'd0);
    check("alias_top_addr", 32'(last_ra), 32'd1023);

    // two loads offered back to back with REQ_VALID held high
    n0 = hs_cnt;
    REQ_WRITE = 1'b0;
    REQ_FUNCT3 = 3'd2;
    REQ_ADDR = 32'h10;
    REQ_VALID = 1'b1;
    for (int k = 0; k < 20 && hs_cnt == n0; k++) begin
      @(posedge CLK);
      #1;
    end
    h1 = hs;
    for (int k = 0; k < 20 && hs_cnt == n0 + 1; k++) begin
      @(posedge CLK);
      #1;
    end
    REQ_VALID = 1'b0;
    check("bp_handshakes", 32'(hs_cnt - n0), 32'd2);
    check("bp_gap", 32'(hs - h1), 32'd3);
    repeat (5) @(posedge CLK);
    #1;

    // reset lands in the WRITE cycle of a halfword store
    issue(1'b1, 3'd1, 32'h12, 32'h00001111);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("rst_writes", 32'(we_cnt - we_base), 32'd0);
    check("rst_resp", 32'(resp_cnt - resp_base), 32'd0);
    check("rst_ram", ram[4], 32'hAAAD7777);
    check("rst_ready", 32'(REQ_READY), 32'd1);
    check("rst_valid", 32'(RESP_VALID), 32'd0);

    for (int n = 0; n < 400; n++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      hi = $urandom;
      a = (hi & 32'hFFFFF000)
        | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      issue(w, f3, a, $urandom);
      if ($urandom_range(0, 3) != 0) wait_resp();
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    repeat (6) @(posedge CLK);
    #1;

    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (ram[i] !== ref_mem[i]) bad++;
    check("ram_image", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the execute stage and the word-wide data RAM (10-bit word address, combinational read, write on rising CLK edge, no byte enables). Accepts one RV32I load or store per request, checks alignment and funct3, and performs sub-word stores by read-modify-write. Returns sign- or zero-extended load data. A multi-cycle FSM with a valid/ready request handshake and a one-cycle response pulse.

## Interface
- No parameters. RAM geometry is fixed at 1024 x 32 bits, word index = byte address [11:2].
- Clocking: one clock, CLK; reset is synchronous and active-high, port RESET.
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous active-high reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  unit can accept; high only in IDLE
- REQ_WRITE  input  1  1 = store, 0 = load
- REQ_FUNCT3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- REQ_ADDR  input  32  byte address
- REQ_WDATA  input  32  store data, low bits used for B/H
- RESP_VALID  output  1  one-cycle pulse, request complete
- RESP_RDATA  output  32  extended load data while RESP_VALID and load; else 0
- RESP_FAULT  output  1  misaligned or illegal funct3; valid with RESP_VALID
- RAM_ADDRESS  output  10  word index to RAM
- RAM_DATA_IN  output  32  write data to RAM
- RAM_WRITE_ENABLE  output  1  RAM write strobe
- RAM_DATA_OUT  input  32  combinational RAM read data

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - REQ_READY=1.
  - Handshake (REQ_VALID & REQ_READY) registers write, funct3, addr, wdata.
  - Next state:
    - RESP if faulted.
    - READ if load, or store with funct3 B/H.
    - WRITE if SW.
- Fault when any of:
  - funct3 ∈ {011,110,111}
  - store with funct3 100/101
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - A faulted request never reads into the response and never writes the RAM.
- READ: word_q ← RAM_DATA_OUT. Next state: RESP (load) or WRITE (store).
- WRITE: RAM_WRITE_ENABLE=1.
  - RAM_DATA_IN for SW: wdata.
  - RAM_DATA_IN for SB: word_q with byte lane addr[1:0] replaced by wdata[7:0].
  - RAM_DATA_IN for SH: word_q with half lane addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP:
  - RESP_VALID=1, RESP_FAULT per registered check.
  - RESP_RDATA is the selected lane of word_q: sign-extended for B/H, zero-extended for BU/HU, whole word for W.
  - RESP_RDATA is 0 for stores and faults.
  - Next state: IDLE. The response has no back-pressure.
- Address bits [31:12] are ignored, so the RAM aliases: 0x1000 maps to word 0, 0xFFC maps to word 1023.
- RAM_ADDRESS = addr_q[11:2] at all times.
- RAM_DATA_IN = 0 outside WRITE.
- Little-endian lanes: byte k = bits [8k+7:8k].

## Timing
- Reset values:
  - state IDLE; all registers 0.
  - REQ_READY=1 from the first cycle after reset.
  - RESP_VALID, RESP_FAULT, RESP_RDATA, RAM_WRITE_ENABLE, RAM_ADDRESS, RAM_DATA_IN all 0.
- Handshake edge = cycle 0. RESP_VALID is high in:
  - cycle 1 for a fault;
  - cycle 2 for a load or SW;
  - cycle 3 for SB/SH.
- Exactly one RAM write per store: SW writes in cycle 1, SB/SH write in cycle 2.
- Next request is accepted no earlier than the cycle after RESP. Peak throughput is one load per 3 cycles.
- REQ_VALID held through busy cycles is ignored until IDLE. Request inputs are sampled only on the handshake edge.
- RESET high at any edge returns to IDLE and drops any pending response.
- RAM_WRITE_ENABLE = (state==WRITE) & ~RESET, so a write coinciding with reset does not commit.

## Structure
- Package mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the 2-bit FSM state encoding;
  - RAM_AW=10.
- One combinational sub-module, load_align: inputs word, addr[1:0], funct3; output extended 32-bit data.
- Store merge and fault check stay inline in mem_access_unit.

## Test plan
- Preload word 4 = 0xDEADBEEF. LW addr 0x10 → RESP_VALID 2 cycles after handshake, RDATA 0xDEADBEEF, FAULT 0, RAM_WRITE_ENABLE never high.
- SB addr 0x13, wdata 0x123456AA → a single RAM_WRITE_ENABLE pulse in cycle 2 with RAM_ADDRESS 4 and DATA_IN 0xAAADBEEF. RESP_VALID in cycle 3 with RDATA 0.
- Follow-up loads on that word:
  - LB 0x13 → 0xFFFFFFAA
  - LBU 0x13 → 0x000000AA
  - LH 0x12 → 0xFFFFAAAD
  - LHU 0x12 → 0x0000AAAD
  - SH 0x10 wdata 0x7777 → word becomes 0xAAAD7777
- Faults, each giving RESP_VALID+FAULT in cycle 1 with no RAM write and RDATA 0:
  - SW 0x06
  - LH 0x11
  - funct3 011
  - store with funct3 100
- Aliasing: LW 0x1000 returns word 0. LW 0xFFC drives RAM_ADDRESS 1023.
- Back-pressure and reset:
  - REQ_VALID held high across two LW → REQ_READY low during READ/RESP; second handshake in the cycle after RESP.
  - RESET asserted in the WRITE cycle of an SH → no write commits, RAM unchanged, all outputs at reset values the next cycle.
